// File: rtl/fp32_accumulator.sv
// fp32_accumulator
// Sums N_TERMS IEEE-754 single-precision products into one result. It is meant
// to sit behind a pipelined multiplier in a 3x3 convolution datapath. Each
// product takes four cycles to go through: IDLE (accept), ALIGN, ADD and NORM.
// The final term adds one DONE cycle that publishes the sum. Denormals are
// flushed to zero and NaN/Inf inputs are clamped to the largest finite
// magnitude, so the block never emits NaN/Inf. Rounding is truncation.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    product strobe from the multiplier
//   in_data     IEEE-754 single product
//   in_ready    high while a product can be accepted (IDLE only)
//   acc_valid   one-cycle pulse, the sum on acc_result is complete
//   acc_result  last completed sum, held until the next one completes
//   term_cnt    products absorbed into the current sum
module fp32_accumulator #(
    parameter int N_TERMS = 9,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             acc_valid,
    output logic [31:0]      acc_result,
    output logic [CNT_W-1:0] term_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, next_state;

    logic             ready_en;
    logic [31:0]      acc;
    logic [31:0]      op_b;
    logic             sign_a_q, sign_b_q;
    logic [23:0]      sig_a_q, sig_b_q;
    logic [7:0]       exp_q;
    logic             sum_sign_q;
    logic [24:0]      sum_q;

    logic             accept;
    logic [CNT_W-1:0] cnt_next;
    logic             last_term;

    // Returns {exponent, 24-bit significand}. A zero exponent field means
    // zero (denormals flushed), and exponent 255 means the largest finite
    // magnitude.
    function automatic logic [31:0] unpack(input logic [31:0] f);
        logic [31:0] r;
        if (f[30:23] == 8'd0)
            r = 32'd0;
        else if (f[30:23] == 8'hFF)
            r = {8'd254, 24'hFFFFFF};
        else
            r = {f[30:23], 1'b1, f[22:0]};
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign cnt_next  = term_cnt + CNT_W'(1);
    assign last_term = (cnt_next == CNT_W'(N_TERMS));

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. Any encoding outside the five states recovers to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = accept ? ALIGN : IDLE;
            ALIGN:   next_state = ADD;
            ADD:     next_state = NORM;
            NORM:    next_state = last_term ? DONE : IDLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs. ready_en keeps in_ready low through the reset cycle. It is set
    // on the first edge after rst is released.
    always_comb begin
        in_ready  = (state == IDLE) && ready_en;
        acc_valid = (state == DONE);
    end

    // Alignment: shift the significand with the smaller exponent right by
    // the exponent difference. Shifts of 25 or more leave nothing.
    logic [31:0] ua, ub;
    logic [7:0]  diff, exp_max;
    logic [23:0] al_a, al_b;
    always_comb begin
        ua      = unpack(acc);
        ub      = unpack(op_b);
        diff    = 8'd0;
        exp_max = 8'd0;
        al_a    = ua[23:0];
        al_b    = ub[23:0];
        if (ua[31:24] >= ub[31:24]) begin
            diff    = ua[31:24] - ub[31:24];
            exp_max = ua[31:24];
            al_b    = (diff >= 8'd25) ? 24'd0 : (ub[23:0] >> diff);
        end else begin
            diff    = ub[31:24] - ua[31:24];
            exp_max = ub[31:24];
            al_a    = (diff >= 8'd25) ? 24'd0 : (ua[23:0] >> diff);
        end
    end

    // Sign-magnitude add. A difference of equal magnitudes is +0.
    logic [24:0] sum_d;
    logic        sum_sign_d;
    always_comb begin
        sum_d      = 25'd0;
        sum_sign_d = 1'b0;
        if (sign_a_q == sign_b_q) begin
            sum_d      = {1'b0, sig_a_q} + {1'b0, sig_b_q};
            sum_sign_d = sign_a_q;
        end else if (sig_a_q > sig_b_q) begin
            sum_d      = {1'b0, sig_a_q} - {1'b0, sig_b_q};
            sum_sign_d = sign_a_q;
        end else if (sig_b_q > sig_a_q) begin
            sum_d      = {1'b0, sig_b_q} - {1'b0, sig_a_q};
            sum_sign_d = sign_b_q;
        end
    end

    // Normalisation. The leading one is brought to bit 23 with a right shift
    // on carry, or a left shift otherwise. The exponent is tracked signed so
    // that overflow (saturate) and underflow (flush to +0) can both be seen.
    logic [4:0]        lead, shift;
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_man;
    logic [31:0]       norm_word;
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 25; i++)
            if (sum_q[i]) lead = 5'(i);
        shift    = 5'd23 - lead;
        norm_exp = 10'sd0;
        norm_man = 23'd0;
        if (sum_q[24]) begin
            norm_man = sum_q[23:1];
            norm_exp = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm_man = sum_q[22:0] << shift;
            norm_exp = $signed({2'b00, exp_q}) - $signed({5'd0, shift});
        end
        if (sum_q == 25'd0)
            norm_word = 32'd0;
        else if (norm_exp > 10'sd254)
            norm_word = {sum_sign_q, 31'h7F7FFFFF};
        else if (norm_exp < 10'sd1)
            norm_word = 32'd0;
        else
            norm_word = {sum_sign_q, norm_exp[7:0], norm_man};
    end

    // Datapath registers. The final sum is copied into acc_result when it is
    // written back. It is therefore already valid while acc_valid is high in
    // DONE, and it holds from then until the next sum completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en   <= 1'b0;
            acc        <= 32'd0;
            op_b       <= 32'd0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            sig_a_q    <= 24'd0;
            sig_b_q    <= 24'd0;
            exp_q      <= 8'd0;
            sum_sign_q <= 1'b0;
            sum_q      <= 25'd0;
            term_cnt   <= '0;
            acc_result <= 32'd0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept)
                        op_b <= in_data;
                end
                ALIGN: begin
                    sign_a_q <= acc[31];
                    sign_b_q <= op_b[31];
                    sig_a_q  <= al_a;
                    sig_b_q  <= al_b;
                    exp_q    <= exp_max;
                end
                ADD: begin
                    sum_q      <= sum_d;
                    sum_sign_q <= sum_sign_d;
                end
                NORM: begin
                    acc      <= norm_word;
                    term_cnt <= cnt_next;
                    if (last_term)
                        acc_result <= norm_word;
                end
                DONE: begin
                    acc      <= 32'd0;
                    term_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accumulator.sv
// tb_fp32_accumulator
// Self-checking bench for fp32_accumulator. A behavioural model tracks the
// expected handshake timing and computes each sum with integer arithmetic
// that follows the alignment, truncation and saturation rules. Directed
// sequences pin known sums, and a randomized phase exercises everything else.
module tb_fp32_accumulator;

    localparam int N  = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic          acc_valid;
    logic [31:0]   acc_result;
    logic [CW-1:0] term_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [31:0] last_result = 32'd0;

    fp32_accumulator #(.N_TERMS(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .acc_valid  (acc_valid),
        .acc_result (acc_result),
        .term_cnt   (term_cnt)
    );

    always #5 clk = ~clk;

    // Compares one value and records a failure if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Reference single-precision add. Operands are aligned with truncation,
    // summed as signed integers, then renormalised. Overflow saturates and
    // underflow flushes to +0.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s, m;
        int ea, eb, e;
        logic sg;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        sa = (ea == 0) ? 0 : (ea == 255) ? 64'hFFFFFF : (64'h800000 + longint'(a[22:0]));
        sb = (eb == 0) ? 0 : (eb == 255) ? 64'hFFFFFF : (64'h800000 + longint'(b[22:0]));
        if (ea == 255) ea = 254;
        if (eb == 255) eb = 254;
        e = (ea > eb) ? ea : eb;
        sa = (e - ea >= 25) ? 0 : (sa >> (e - ea));
        sb = (e - eb >= 25) ? 0 : (sb >> (e - eb));
        s = (a[31] ? -sa : sa) + (b[31] ? -sb : sb);
        if (s == 0) return 32'd0;
        sg = (s < 0);
        m  = sg ? -s : s;
        while (m >= 64'h1000000) begin m = m >> 1; e++; end
        while (m < 64'h800000) begin m = m << 1; e--; end
        if (e > 254) return {sg, 31'h7F7FFFFF};
        if (e < 1)   return 32'd0;
        return {sg, 8'(e), m[22:0]};
    endfunction

    // Model state. Phase counts the cycles since a product was accepted
    // (0 = waiting, 1..3 = in flight, 4 = publishing the sum).
    int          m_phase = 0;
    logic        m_rdy   = 1'b0;
    logic [31:0] m_acc   = 32'd0;
    logic [31:0] m_b     = 32'd0;
    logic [31:0] m_result = 32'd0;
    int          m_cnt   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_rdy = 1'b0; m_acc = 32'd0; m_cnt = 0; m_result = 32'd0;
        end else begin
            if (m_phase == 0) begin
                if (in_valid && m_rdy) begin m_b = in_data; m_phase = 1; end
            end else if (m_phase < 3) begin
                m_phase++;
            end else if (m_phase == 3) begin
                m_acc = m_add(m_acc, m_b);
                m_cnt++;
                if (m_cnt == N) begin m_result = m_acc; m_phase = 4; end
                else m_phase = 0;
            end else begin
                m_acc = 32'd0; m_cnt = 0; m_phase = 0;
            end
            m_rdy = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checkOutput("in_ready", 32'(in_ready), 32'(m_phase == 0 && m_rdy));
        checkOutput("acc_valid", 32'(acc_valid), 32'(m_phase == 4));
        checkOutput("acc_result", acc_result, m_result);
        checkOutput("term_cnt", 32'(term_cnt), 32'(m_cnt));
        if (acc_valid) begin
            pulses++;
            last_result = acc_result;
        end
    end

    // Sends one product as soon as in_ready allows, with a bounded wait.
    task automatic applyStimulus(input logic [31:0] data);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin @(negedge clk); waited++; end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready 0, required 1");
        end else begin
            in_valid = 1'b1;
            in_data  = data;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = $urandom;
        end
    endtask

    // Waits (bounded) for a completed sum, then checks the pulse count since
    // `start` and the published value.
    task automatic waitResult(input string name, input logic [31:0] exp, input int start);
        int t = 0;
        while (pulses == start && t < 40) begin @(posedge clk); t++; end
        repeat (3) @(negedge clk);
        checkOutput({name, "_pulses"}, 32'(pulses - start), 32'd1);
        checkOutput(name, last_result, exp);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0)      r[30:23] = 8'd0;
        else if (k == 1) r[30:23] = 8'hFF;
        else if (k < 12) r[30:23] = 8'($urandom_range(120, 135));
        else             r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    initial begin
        int start;
        int t;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_acc_valid", 32'(acc_valid), 32'd0);
        checkOutput("reset_result", acc_result, 32'd0);
        checkOutput("reset_term_cnt", 32'(term_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1 checkOutput("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1 checkOutput("ready_after_edge", 32'(in_ready), 32'd1);

        // Hand-computed sums that pin the reference model.
        checkOutput("model_1_plus_1", m_add(32'h3F800000, 32'h3F800000), 32'h40000000);
        checkOutput("model_cancel", m_add(32'h3F800000, 32'hBF800000), 32'h00000000);
        checkOutput("model_2_minus_1", m_add(32'h40000000, 32'hBF800000), 32'h3F800000);
        checkOutput("model_align_limit", m_add(32'h4B800000, 32'h3F800000), 32'h4B800000);
        checkOutput("model_saturate", m_add(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F7FFFFF);
        checkOutput("model_inf_clamp", m_add(32'h0, 32'hFF800000), 32'hFF7FFFFF);
        checkOutput("model_denorm_flush", m_add(32'h0, 32'h00400000), 32'h00000000);

        $display("[TB] nine ones");
        start = pulses;
        for (int i = 0; i < 9; i++) applyStimulus(32'h3F800000);
        waitResult("sum_nine_ones", 32'h41100000, start);
        checkOutput("term_cnt_cleared", 32'(term_cnt), 32'd0);

        $display("[TB] alternating signs");
        start = pulses;
        for (int i = 0; i < 9; i++) applyStimulus((i % 2) ? 32'hBF800000 : 32'h3F800000);
        waitResult("sum_alternating", 32'h3F800000, start);
        start = pulses;
        for (int i = 0; i < 8; i++) applyStimulus((i % 2) ? 32'hBF800000 : 32'h3F800000);
        applyStimulus(32'h00000000);
        waitResult("sum_cancel_zero", 32'h00000000, start);

        $display("[TB] saturation");
        start = pulses;
        applyStimulus(32'h7F7FFFFF);
        applyStimulus(32'h7F7FFFFF);
        for (int i = 0; i < 7; i++) applyStimulus(32'h00000000);
        waitResult("sum_saturated", 32'h7F7FFFFF, start);

        $display("[TB] in_valid held high");
        start = pulses;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h40000000;
        t = 0;
        while (pulses == start && t < 100) begin @(posedge clk); t++; end
        #1 in_valid = 1'b0;
        waitResult("sum_held_valid", 32'h41900000, start);

        $display("[TB] reset mid-sum");
        start = pulses;
        for (int i = 0; i < 5; i++) applyStimulus(32'h3F800000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) applyStimulus(32'h3F800000);
        waitResult("sum_after_abort", 32'h41100000, start);

        $display("[TB] alignment limit");
        start = pulses;
        applyStimulus(32'h4B800000);
        applyStimulus(32'h3F800000);
        for (int i = 0; i < 7; i++) applyStimulus(32'h00000000);
        waitResult("sum_align_limit", 32'h4B800000, start);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand_fp();
            rst      = ($urandom_range(0, 299) == 0);
        end
        #1 rst = 1'b0; in_valid = 1'b0;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
